// File: rtl/srrc_pkg.sv
// srrc_pkg: shared widths, timing constants, state encoding and default SRRC coefficients
package srrc_pkg;
    localparam int W     = 18;
    localparam int NCOEF = 9;
    localparam int OSR   = 4;
    localparam int FLUSH = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic signed [W-1:0] COEF_DEF [NCOEF] = '{
        18'sd314, -18'sd2115, -18'sd5743, -18'sd6936, -18'sd719,
        18'sd15367, 18'sd37897, 18'sd57966, 18'sd66023
    };
endpackage

// File: rtl/srrc_coef_bank.sv
// srrc_coef_bank: shadow/active coefficient banks; a pending commit copies on the next boundary
module srrc_coef_bank
    import srrc_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic [3:0]         i_addr,
    input  logic [W-1:0]       i_data,
    input  logic               i_commit,
    input  logic               i_boundary,
    output logic               o_pending,
    output logic [NCOEF*W-1:0] o_bus
);
    logic signed [W-1:0] r_shadow [NCOEF];
    logic signed [W-1:0] r_active [NCOEF];
    logic                r_pending;
    logic                w_apply;

    assign w_apply   = r_pending && i_boundary;
    assign o_pending = r_pending;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow  <= COEF_DEF;
            r_active  <= COEF_DEF;
            r_pending <= 1'b0;
        end else begin
            if (i_wr && i_addr < 4'(NCOEF)) r_shadow[i_addr] <= i_data;
            if (w_apply) r_active <= r_shadow;
            r_pending <= !w_apply && (r_pending || i_commit);
        end
    end

    genvar k;
    generate
        for (k = 0; k < NCOEF; k++) begin : g_bus
            assign o_bus[k*W +: W] = r_active[k];
        end
    endgenerate
endmodule

// File: rtl/srrc_tx_ctrl.sv
// srrc_tx_ctrl: zero-stuffing symbol sequencer for the SRRC TX filter with boundary-aligned coefficient updates
module srrc_tx_ctrl
    import srrc_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [W-1:0]       i_sym_in,
    input  logic               i_sym_valid,
    output logic               o_sym_ready,
    output logic [W-1:0]       o_flt_in,
    output logic               o_sym_strobe,
    output logic               o_underrun,
    input  logic               i_coef_wr,
    input  logic [3:0]         i_coef_addr,
    input  logic [W-1:0]       i_coef_data,
    input  logic               i_coef_commit,
    output logic               o_coef_pending,
    output logic [NCOEF*W-1:0] o_coef_bus
);
    localparam int PW = $clog2(OSR);
    localparam int DW = $clog2(FLUSH + 1);

    state_t         r_state, w_state_n;
    logic [PW-1:0]  r_phase, w_phase_n;
    logic [DW-1:0]  r_drain, w_drain_n;
    logic [W-1:0]   r_flt, w_flt_n;
    logic           r_strobe, w_strobe_n;
    logic           r_under, w_under_n;
    logic           w_last;
    logic           w_hs;

    assign w_last      = r_phase == PW'(OSR - 1);
    assign o_sym_ready = !i_reset && (r_state == S_IDLE || w_last);
    assign w_hs        = i_sym_valid && o_sym_ready;

    always_comb begin
        w_state_n  = r_state;
        w_phase_n  = w_last ? '0 : r_phase + 1'b1;
        w_drain_n  = r_drain;
        w_flt_n    = '0;
        w_strobe_n = 1'b0;
        w_under_n  = 1'b0;
        if (w_hs) begin
            w_state_n  = S_RUN;
            w_phase_n  = '0;
            w_drain_n  = '0;
            w_flt_n    = i_sym_in;
            w_strobe_n = 1'b1;
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                w_state_n = S_DRAIN;
                w_drain_n = DW'(1);
                w_under_n = 1'b1;
            end
        end else if (r_state == S_DRAIN) begin
            w_drain_n = r_drain + 1'b1;
            if (r_drain == DW'(FLUSH)) begin
                w_state_n = S_IDLE;
                w_phase_n = '0;
                w_drain_n = '0;
            end
        end else begin
            w_state_n = S_IDLE;
            w_phase_n = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_drain  <= '0;
            r_flt    <= '0;
            r_strobe <= 1'b0;
            r_under  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_phase  <= w_phase_n;
            r_drain  <= w_drain_n;
            r_flt    <= w_flt_n;
            r_strobe <= w_strobe_n;
            r_under  <= w_under_n;
        end
    end

    assign o_flt_in     = r_flt;
    assign o_sym_strobe = r_strobe;
    assign o_underrun   = r_under;

    // Outside RUN there is no symbol grid to respect, so a pending copy goes at once
    srrc_coef_bank u_bank (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr       (i_coef_wr),
        .i_addr     (i_coef_addr),
        .i_data     (i_coef_data),
        .i_commit   (i_coef_commit),
        .i_boundary (w_hs || r_state != S_RUN),
        .o_pending  (o_coef_pending),
        .o_bus      (o_coef_bus)
    );
endmodule

// File: tb/tb_srrc_tx_ctrl.sv
// tb_srrc_tx_ctrl: directed and randomized checks of srrc_tx_ctrl against a symbol-timeline model
module tb_srrc_tx_ctrl;
    localparam int W = 18, NC = 9, OSR = 4, FLUSH = 16;

    logic clk = 1'b0;
    logic rst, valid, wr, cmt;
    logic [W-1:0] sym, data, flt;
    logic [3:0] addr;
    logic ready, strobe, und, pend;
    logic [NC*W-1:0] bus;

    always #5 clk = ~clk;

    srrc_tx_ctrl dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_sym_in       (sym),
        .i_sym_valid    (valid),
        .o_sym_ready    (ready),
        .o_flt_in       (flt),
        .o_sym_strobe   (strobe),
        .o_underrun     (und),
        .i_coef_wr      (wr),
        .i_coef_addr    (addr),
        .i_coef_data    (data),
        .i_coef_commit  (cmt),
        .o_coef_pending (pend),
        .o_coef_bus     (bus)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    localparam logic signed [W-1:0] DEF [NC] = '{
        18'sd314, -18'sd2115, -18'sd5743, -18'sd6936, -18'sd719,
        18'sd15367, 18'sd37897, 18'sd57966, 18'sd66023
    };

    // Model: the last symbol issue cycle fixes the phase grid, the RUN window and the drain window
    bit m_known = 0, m_active = 0, m_str = 0, m_und = 0, m_pend = 0;
    longint cyc = 0, m_s = 0;
    logic signed [W-1:0] m_flt = '0;
    logic signed [W-1:0] m_sh [NC];
    logic signed [W-1:0] m_ac [NC];

    always @(negedge clk) begin
        bit idle, exp_rdy, hs, run, apply;
        idle    = !m_active || cyc >= m_s + OSR + FLUSH;
        exp_rdy = !rst && (idle || (cyc - m_s) % OSR == OSR - 1);
        if (m_known) begin
            chk("sym_ready", ready, exp_rdy);
            chk("flt_in", $signed(flt), m_flt);
            chk("sym_strobe", strobe, m_str);
            chk("underrun", und, m_und);
            chk("coef_pending", pend, m_pend);
            for (int k = 0; k < NC; k++) chk("coef_bus", $signed(bus[k*W +: W]), m_ac[k]);
        end
        if (rst) begin
            m_known = 1; m_active = 0; m_flt = '0; m_str = 0; m_und = 0; m_pend = 0;
            m_sh = DEF; m_ac = DEF;
        end else begin
            hs    = valid && exp_rdy;
            run   = m_active && cyc < m_s + OSR;
            apply = m_pend && (hs || !run);
            if (apply) m_ac = m_sh;
            m_pend = !apply && (m_pend || cmt);
            if (wr && int'(addr) < NC) m_sh[addr] = data;
            m_str = hs;
            m_flt = hs ? $signed(sym) : '0;
            m_und = !hs && m_active && cyc + 1 == m_s + OSR;
            if (hs) begin
                m_active = 1;
                m_s = cyc + 1;
            end
        end
        cyc++;
    end

    longint st_t[$], un_t[$];
    logic signed [W-1:0] st_v[$];
    bit rd_h [longint];

    always @(negedge clk) begin
        if (strobe === 1'b1) begin
            st_t.push_back(longint'($time / 10));
            st_v.push_back($signed(flt));
        end
        if (und === 1'b1) un_t.push_back(longint'($time / 10));
        rd_h[longint'($time / 10)] = (ready === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [W-1:0] v);
        bit done = 0;
        valid = 1'b1;
        sym = v;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = ready;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    initial begin
        int feed;
        longint u2;
        rst = 1; valid = 0; sym = '0; wr = 0; addr = '0; data = '0; cmt = 0;
        tick(3);
        rst = 0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_flt", $signed(flt), 0);
        chk("rst_b0", $signed(bus[0 +: W]), 314);
        chk("rst_b8", $signed(bus[8*W +: W]), 66023);
        @(posedge clk); #1;

        st_t.delete(); st_v.delete(); un_t.delete();
        send(18'sd100); send(-18'sd200); send(18'sd300);
        tick(1);
        chk("seq_count", st_v.size(), 3);
        if (st_v.size() == 3) begin
            chk("seq0", st_v[0], 100);
            chk("seq1", st_v[1], -200);
            chk("seq2", st_v[2], 300);
            chk("seq_gap1", st_t[1] - st_t[0], 4);
            chk("seq_gap2", st_t[2] - st_t[1], 4);
        end

        for (int i = 0; i < 20 && un_t.size() == 0; i++) tick(1);
        chk("underrun_seen", un_t.size(), 1);
        tick(4);
        send(-18'sd7);
        tick(1);
        chk("resume_grid", st_t[st_t.size()-1] - un_t[0], 8);
        chk("resume_val", st_v[st_v.size()-1], -7);
        chk("underrun_once", un_t.size(), 1);
        tick(30);
        chk("underrun_two", un_t.size(), 2);
        u2 = un_t[un_t.size()-1];
        chk("drain_rdy14", rd_h[u2+14], 0);
        chk("drain_rdy15", rd_h[u2+15], 1);
        chk("drain_rdy16", rd_h[u2+16], 1);
        chk("drain_rdy17", rd_h[u2+17], 1);

        send(18'sd5);
        valid = 1; sym = 18'sd6;
        wr = 1; addr = 4'd8; data = 18'sd1000;
        tick(1);
        wr = 0; cmt = 1;
        tick(1);
        cmt = 0;
        @(negedge clk);
        chk("cw_hold_b8", $signed(bus[8*W +: W]), 66023);
        chk("cw_pending", pend, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cw_hold2_b8", $signed(bus[8*W +: W]), 66023);
        @(posedge clk); #1;
        valid = 0;
        @(negedge clk);
        chk("cw_strobe", strobe, 1);
        chk("cw_b8", $signed(bus[8*W +: W]), 1000);
        chk("cw_pend_clr", pend, 0);
        @(posedge clk); #1;
        wr = 1; addr = 4'd9; data = 18'sd77;
        tick(1);
        wr = 0; cmt = 1;
        tick(1);
        cmt = 0;
        tick(30);
        chk("a9_b8", $signed(bus[8*W +: W]), 1000);
        chk("a9_b0", $signed(bus[0 +: W]), 314);
        chk("a9_b1", $signed(bus[1*W +: W]), -2115);
        chk("a9_pend", pend, 0);

        wr = 1; addr = 4'd0; data = -18'sd5; cmt = 1;
        tick(1);
        wr = 0; cmt = 0;
        @(negedge clk);
        chk("idle_pend", pend, 1);
        chk("idle_b0_old", $signed(bus[0 +: W]), 314);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_b0_new", $signed(bus[0 +: W]), -5);
        @(posedge clk); #1;
        wr = 1; addr = 4'd3; data = 18'sd42; cmt = 1;
        tick(1);
        wr = 0;
        tick(1);
        cmt = 0; wr = 1; data = 18'sd43;
        tick(1);
        wr = 0;
        tick(2);
        @(negedge clk);
        chk("dbl_b3", $signed(bus[3*W +: W]), 42);
        chk("dbl_pend", pend, 0);
        @(posedge clk); #1;

        valid = 1; sym = 18'sd9;
        tick(6);
        rst = 1; valid = 0;
        tick(1);
        rst = 0;
        @(negedge clk);
        chk("mid_rst_flt", $signed(flt), 0);
        chk("mid_rst_strobe", strobe, 0);
        chk("mid_rst_b0", $signed(bus[0 +: W]), 314);
        chk("mid_rst_b3", $signed(bus[3*W +: W]), -6936);
        chk("mid_rst_ready", ready, 1);
        @(posedge clk); #1;

        feed = 70;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) feed = (i / 200) % 3 == 0 ? 100 : ((i / 200) % 3 == 1 ? 70 : 15);
            valid = $urandom_range(0, 99) < feed;
            sym   = W'($urandom);
            wr    = $urandom_range(0, 4) == 0;
            addr  = 4'($urandom_range(0, 15));
            data  = W'($urandom);
            cmt   = $urandom_range(0, 9) == 0;
            rst   = $urandom_range(0, 199) == 0;
            tick(1);
        end
        rst = 0; valid = 0; wr = 0; cmt = 0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
